// File: rtl/dmem_responder.sv
// Data-memory responder: req/ack load/store target with RV32I byte/half/word access and programmable wait states.
// Optional build macro DMEM_MISALIGN_ERR_EN: flag misaligned half/word accesses as errors instead of force-aligning them.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  memReq,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           writeData,
  output logic                  memAck,
  output logic [31:0]           readData,
  output logic                  memErr,
  output logic                  busy
);

  // state   | meaning
  // IDLE    | waiting for memReq; request fields latched on accept
  // ACCESS  | wait-state countdown; array op on the terminal count
  // RESPOND | one-cycle memAck with readData/memErr valid

  localparam int         IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t           state, state_nxt;
  logic [3:0]       wait_cnt;
  logic             l_write;
  logic [2:0]       l_funct3;
  logic [IDX_W+1:0] l_addr;
  logic [31:0]      l_wdata;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic [31:0]      cur_word, load_val, store_word;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             bad_f3, misalign, req_err, commit;
  logic             unused_addr_hi;

  assign unused_addr_hi = &{1'b0, addr[ADDR_WIDTH-1:IDX_W+2]};

  assign idx      = l_addr[IDX_W+1:2];
  assign lane     = l_addr[1:0];
  assign cur_word = mem[idx];
  assign commit   = (state == S_ACCESS) && (wait_cnt == 4'd0);

  always_comb begin
    if (l_write) bad_f3 = l_funct3[2] | (l_funct3[1:0] == 2'b11);
    else         bad_f3 = (l_funct3 == 3'b011) | (l_funct3[2:1] == 2'b11);
  end

`ifdef DMEM_MISALIGN_ERR_EN
  assign misalign = ((l_funct3[1:0] == 2'b01) && lane[0]) ||
                    ((l_funct3[1:0] == 2'b10) && (lane != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = bad_f3 | misalign;

  always_comb begin
    ld_byte = 8'h00;
    case (lane)
      2'd0:    ld_byte = cur_word[7:0];
      2'd1:    ld_byte = cur_word[15:8];
      2'd2:    ld_byte = cur_word[23:16];
      default: ld_byte = cur_word[31:24];
    endcase
    ld_half = lane[1] ? cur_word[31:16] : cur_word[15:0];
    case (l_funct3)
      3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'h0, ld_byte};
      3'b101:  load_val = {16'h0, ld_half};
      default: load_val = 32'h0;
    endcase
  end

  // Merge store data into the current word, touching only the addressed lanes.
  always_comb begin
    store_word = cur_word;
    case (l_funct3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    store_word[7:0]   = l_wdata[7:0];
          2'd1:    store_word[15:8]  = l_wdata[7:0];
          2'd2:    store_word[23:16] = l_wdata[7:0];
          default: store_word[31:24] = l_wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) store_word[31:16] = l_wdata[15:0];
        else         store_word[15:0]  = l_wdata[15:0];
      end
      2'b10:   store_word = l_wdata;
      default: store_word = cur_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      readData <= 32'h0;
      memErr   <= 1'b0;
      l_write  <= 1'b0;
      l_funct3 <= 3'b000;
      l_addr   <= '0;
      l_wdata  <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && memReq) begin
        l_write  <= memWrite;
        l_funct3 <= funct3;
        l_addr   <= addr[IDX_W+1:0];
        l_wdata  <= writeData;
        wait_cnt <= WAIT_INIT;
      end else if (state == S_ACCESS) begin
        if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
        end else begin
          readData <= (req_err || l_write) ? 32'h0 : load_val;
          memErr   <= req_err;
        end
      end
    end
  end

  // Array has no reset; a store is dropped if rst lands on its commit edge.
  always_ff @(posedge clk) begin
    if (!rst && commit && l_write && !req_err)
      mem[idx] <= store_word;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (memReq) state_nxt = S_ACCESS;
      S_ACCESS:  if (wait_cnt == 4'd0) state_nxt = S_RESPOND;
      S_RESPOND: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    memAck = (state == S_RESPOND);
    busy   = (state != S_IDLE);
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (default parameters).
// Misalign expectations follow DMEM_MISALIGN_ERR_EN when the bench is built with it.
module tb_dmem_responder;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        memReq, memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr, writeData;
  logic        memAck, memErr, busy;
  logic [31:0] readData;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(W), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .memReq(memReq), .memWrite(memWrite), .funct3(funct3),
    .addr(addr), .writeData(writeData), .memAck(memAck), .readData(readData),
    .memErr(memErr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one request and returns response fields plus edges until memAck (timeout gives 40+).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int cyc);
    @(negedge clk);
    memReq = 1'b1; memWrite = wr; funct3 = f3; addr = a; writeData = wd;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      memReq = 1'b0;
      cyc++;
    end while (!memAck && cyc < 40);
    rd  = readData;
    err = memErr;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int acks = 0;
    rst = 1'b1; memReq = 1'b0; memWrite = 1'b0; funct3 = 3'b0; addr = 32'h0; writeData = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (memAck !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", memAck); end
    checks++; if (readData !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", readData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (memErr !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", memErr); end
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (memAck === 1'b1 || busy === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL idle_no_ack got=%0d exp=0", acks); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic err; int cyc;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, err, cyc);
    checks++; if (cyc !== W + 2) begin failures++; $display("FAIL sw_latency got=%0d exp=%0d", cyc, W + 2); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL sw_rdata got=%h exp=0", rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, err, cyc);
    checks++; if (cyc !== W + 2) begin failures++; $display("FAIL lw_latency got=%0d exp=%0d", cyc, W + 2); end
    checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL lw_err got=%b exp=0", err); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic err; int cyc;
    do_req(1'b1, 3'b010, 32'h20, 32'h00000000, rd, err, cyc);
    do_req(1'b1, 3'b000, 32'h23, 32'h00000080, rd, err, cyc);
    do_req(1'b0, 3'b000, 32'h23, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h23, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu got=%h exp=00000080", rd); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h80000000) begin failures++; $display("FAIL lw_after_sb got=%h exp=80000000", rd); end
    do_req(1'b1, 3'b000, 32'h21, 32'h000000A5, rd, err, cyc);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h8000A500) begin failures++; $display("FAIL sb_lane1 got=%h exp=8000a500", rd); end
  endtask

  task automatic test_half();
    logic [31:0] rd; logic err; int cyc;
    do_req(1'b1, 3'b010, 32'h30, 32'h1234ABCD, rd, err, cyc);
    do_req(1'b1, 3'b001, 32'h32, 32'hFFFF8001, rd, err, cyc);
    do_req(1'b0, 3'b001, 32'h32, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'hFFFF8001) begin failures++; $display("FAIL lh got=%h exp=ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h32, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h00008001) begin failures++; $display("FAIL lhu got=%h exp=00008001", rd); end
    do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h8001ABCD) begin failures++; $display("FAIL lw_after_sh got=%h exp=8001abcd", rd); end
    do_req(1'b0, 3'b101, 32'h30, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h0000ABCD) begin failures++; $display("FAIL lhu_low got=%h exp=0000abcd", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int cyc;
    do_req(1'b1, 3'b010, 32'h40, 32'h11223344, rd, err, cyc);
`ifdef DMEM_MISALIGN_ERR_EN
    do_req(1'b0, 3'b010, 32'h41, 32'h0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL mis_lw_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL mis_lw_rdata got=%h exp=0", rd); end
    checks++; if (cyc !== W + 2) begin failures++; $display("FAIL mis_latency got=%0d exp=%0d", cyc, W + 2); end
    do_req(1'b1, 3'b010, 32'h42, 32'hAAAAAAAA, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL mis_sw_err got=%b exp=1", err); end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL mis_sw_nowrite got=%h exp=11223344", rd); end
`else
    do_req(1'b0, 3'b010, 32'h41, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL align_lw got=%h exp=11223344", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL align_lw_err got=%b exp=0", err); end
    do_req(1'b0, 3'b101, 32'h43, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h00001122) begin failures++; $display("FAIL align_lhu got=%h exp=00001122", rd); end
`endif
    do_req(1'b0, 3'b011, 32'h40, 32'h0, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_f3_err got=%b exp=1", err); end
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL bad_f3_rdata got=%h exp=0", rd); end
    do_req(1'b1, 3'b100, 32'h40, 32'hFFFFFFFF, rd, err, cyc);
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL bad_store_err got=%b exp=1", err); end
    do_req(1'b0, 3'b010, 32'h40, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h11223344) begin failures++; $display("FAIL bad_store_nowrite got=%h exp=11223344", rd); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clears got=%b exp=0", err); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] rd; logic err; int cyc; int acks = 0;
    do_req(1'b1, 3'b010, 32'h50, 32'hCAFEF00D, rd, err, cyc);
    @(negedge clk);
    memReq = 1'b1; memWrite = 1'b1; funct3 = 3'b010; addr = 32'h50; writeData = 32'h12345678;
    @(posedge clk); #1;
    memReq = 1'b0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midop_busy got=%b exp=1", busy); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy_after_rst got=%b exp=0", busy); end
    repeat (6) begin
      if (memAck === 1'b1) acks++;
      @(posedge clk); #1;
    end
    checks++; if (acks !== 0) begin failures++; $display("FAIL midop_no_ack got=%0d exp=0", acks); end
    do_req(1'b0, 3'b010, 32'h50, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL midop_old_value got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd; logic err; int cyc;
    do_req(1'b1, 3'b010, 32'h1000, 32'h5A5AA5A5, rd, err, cyc);
    do_req(1'b0, 3'b010, 32'h0, 32'h0, rd, err, cyc);
    checks++; if (rd !== 32'h5A5AA5A5) begin failures++; $display("FAIL wrap got=%h exp=5a5aa5a5", rd); end
  endtask

  task automatic test_back_to_back();
    int edges = 0; int acks = 0;
    @(negedge clk);
    memReq = 1'b1; memWrite = 1'b0; funct3 = 3'b010; addr = 32'h10; writeData = 32'h0;
    repeat (2 * (W + 3)) begin
      @(posedge clk); #1;
      edges++;
      if (memAck === 1'b1) begin
        acks++;
        checks++;
        if (edges !== acks * (W + 3) - 1) begin
          failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", edges, acks * (W + 3) - 1);
        end
      end
    end
    memReq = 1'b0;
    checks++; if (acks !== 2) begin failures++; $display("FAIL b2b_acks got=%0d exp=2", acks); end
    repeat (W + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_midop();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the multi-cycle core: the target end of the memory interface that the main controller drives during its MEMORY/WRITEBACK states.
- Accepts one load or store request at a time over a req/ack handshake and performs RV32I byte, halfword or word access against an internal word-organised array.
- Performs sign or zero extension on loads, and applies byte-lane masking on stores.
- Inserts a programmable number of wait states so the controller's stall handling can be exercised.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of 2 and at least 2.
- WAIT_CYCLES, 1: extra ACCESS-state cycles per request, range 0..15.
- ADDR_WIDTH, 32: width of the byte address.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memReq  in  1  request valid; sampled only in IDLE.
- memWrite  in  1  1 = store, 0 = load; sampled together with memReq.
- funct3  in  3  RV32I load/store width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- addr  in  ADDR_WIDTH  byte address.
- writeData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- memAck  out  1  one-cycle completion pulse.
- readData  out  32  load result, valid when memAck=1.
- memErr  out  1  error flag, valid when memAck=1.
- busy  out  1  high while a request is in flight.

Behaviour:
- Reset: one clock, synchronous, active-high. On the rst edge: state=IDLE, memAck=0, readData=0, memErr=0, busy=0, wait counter=0. Array contents are not cleared.
- Reset mid-operation: an in-flight request is dropped with no ack. A store not yet committed is not written.
- State machine:
  - IDLE: if memReq=1, latch memWrite, funct3, addr and writeData, then go to ACCESS.
  - ACCESS: lasts WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter. On the edge where the count reaches 0, perform the array op and go to RESPOND.
  - RESPOND: memAck=1 for exactly one cycle, then go to IDLE.
- memReq is ignored in ACCESS and RESPOND.
- Latency: memReq sampled high in IDLE at cycle N gives memAck=1 at cycle N+2+WAIT_CYCLES.
- Back-to-back requests: memReq held high through RESPOND is next sampled in the IDLE cycle that follows. Minimum request spacing is WAIT_CYCLES+3 cycles.
- busy=1 in ACCESS and RESPOND, 0 in IDLE.
- Addressing:
  - Word index = addr[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
  - Byte lane = addr[1:0].
- Loads:
  - Lane-select the byte (lane 0..3) or half (addr[1]=0 gives [15:0], 1 gives [31:16]).
  - funct3 000/001 sign-extend to 32 bits; 100/101 zero-extend; 010 passes the full word.
- Stores:
  - Read-modify-write of one array word, affecting only the addressed lanes.
  - SB writes writeData[7:0] to the lane; SH writes writeData[15:0] to the half; SW writes the whole word.
  - readData=0 in the RESPOND cycle of a store.
- Invalid funct3 (011, 110, 111, or a store with 1xx): the request completes normally with memErr=1, no array write, readData=0.
- readData and memErr hold their values after RESPOND until the next RESPOND. Consumers sample them only while memAck=1.
- The array op is committed exactly once per request. A load in the same RESPOND cycle as a pending store cannot occur, because only one request is in flight at a time.

Optional Feature:
- Macro: DMEM_MISALIGN_ERR_EN
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, completes with memErr=1.
  - No array write occurs and readData=0.
  - Latency is unchanged.
- Undefined:
  - Misaligned addresses are forced down to alignment: half uses addr[1] only, word ignores addr[1:0].
  - The access proceeds normally. memErr is asserted only for invalid funct3.

Test Plan:
- Reset then idle: rst high 2 cycles -> memAck=0, readData=0, busy=0; memReq=0 for 10 cycles -> memAck stays 0.
- SW then LW: SW addr=0x10, data=0xDEADBEEF, then LW addr=0x10 with WAIT_CYCLES=1 -> each memAck arrives exactly 3 cycles after memReq is sampled; readData=0xDEADBEEF, memErr=0.
- Byte lanes:
  - Store SW 0x00000000 at 0x20, then SB 0x80 at 0x23.
  - LB 0x23 -> 0xFFFFFF80; LBU 0x23 -> 0x00000080; LW 0x20 -> 0x80000000.
- Halfword:
  - SH 0x8001 at 0x32.
  - LH 0x32 -> 0xFFFF8001; LHU 0x32 -> 0x00008001; LW 0x30 -> 0x8001xxxx, with the low half unchanged.
- Misalign and invalid cases:
  - With DMEM_MISALIGN_ERR_EN, LW 0x41 -> memErr=1, readData=0; SW 0x42 -> memErr=1 and word 0x40 unchanged.
  - Without the macro, LW 0x41 returns the word at 0x40.
  - funct3=011 -> memErr=1 in both builds.
- Reset mid-op and wrap:
  - Assert rst during ACCESS of SW 0x50 = 0x12345678 -> no memAck; a later LW 0x50 returns the old value.
  - With DEPTH_WORDS=1024, SW at 0x1000 then LW at 0x0 -> returns the same data (wrap).
